// File: rtl/tape_pkg.sv
// Shared definitions for the tape controller: command opcodes, FSM states
// and default tape geometry.
package tape_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 8;
    localparam int unsigned ADDR_WIDTH_DEF = 6;
    localparam int unsigned OP_WIDTH       = 3;

    typedef enum logic [OP_WIDTH-1:0] {
        OP_NOP   = 3'd0,
        OP_INC   = 3'd1,
        OP_DEC   = 3'd2,
        OP_RIGHT = 3'd3,
        OP_LEFT  = 3'd4,
        OP_IN    = 3'd5,
        OP_OUT   = 3'd6,
        OP_RSVD  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_WAIT_IN,
        ST_WAIT_OUT
    } state_e;

endpackage

// File: rtl/tape_ctrl.sv
// Tape data-path controller: executes decoded cell/pointer/IO commands and
// drives the write-every-cycle tape RAM, holding the cell unless it changes.
module tape_ctrl
    import tape_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [OP_WIDTH-1:0]   cmd_op,
    input  logic [DATA_WIDTH-1:0] cmd_arg,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  cell_zero,
    output logic [ADDR_WIDTH-1:0] ptr
);

    state_e                state, state_d;
    op_e                   op_q, op_d;
    logic [DATA_WIDTH-1:0] arg_q, arg_d;
    logic [ADDR_WIDTH-1:0] ptr_d;
    logic                  out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_d;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            op_q      <= OP_NOP;
            arg_q     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            state     <= state_d;
            ptr       <= ptr_d;
            op_q      <= op_d;
            arg_q     <= arg_d;
            out_valid <= out_valid_d;
            out_data  <= out_data_d;
        end
    end

    // ram_wdata is fed only by registered op/arg, ram_rdata and in_data,
    // never combinationally by cmd_*.
    always_comb begin
        state_d     = state;
        ptr_d       = ptr;
        op_d        = op_q;
        arg_d       = arg_q;
        out_valid_d = out_valid;
        out_data_d  = out_data;
        ram_wdata   = ram_rdata;
        unique case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    op_d  = op_e'(cmd_op);
                    arg_d = cmd_arg;
                    case (op_e'(cmd_op))
                        OP_IN:   state_d = ST_WAIT_IN;
                        OP_OUT: begin
                            state_d     = ST_WAIT_OUT;
                            out_valid_d = 1'b1;
                            out_data_d  = ram_rdata;
                        end
                        default: state_d = ST_EXEC;
                    endcase
                end
            end
            ST_EXEC: begin
                state_d = ST_IDLE;
                case (op_q)
                    OP_INC:   ram_wdata = ram_rdata + arg_q;
                    OP_DEC:   ram_wdata = ram_rdata - arg_q;
                    OP_RIGHT: ptr_d     = ptr + ADDR_WIDTH'(arg_q);
                    OP_LEFT:  ptr_d     = ptr - ADDR_WIDTH'(arg_q);
                    default:  ;
                endcase
            end
            ST_WAIT_IN: begin
                if (in_valid) begin
                    ram_wdata = in_data;
                    state_d   = ST_IDLE;
                end
            end
            ST_WAIT_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign cmd_ready = (state == ST_IDLE);
    assign in_ready  = (state == ST_WAIT_IN);
    assign ram_addr  = ptr;
    assign cell_zero = (ram_rdata == '0);

endmodule

// File: tb/tb_tape_ctrl.sv
// Self-checking bench for tape_ctrl with a behavioural tape RAM and a
// reference model of pointer and cell contents.
module tb_tape_ctrl;
    import tape_pkg::*;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 6;
    localparam int unsigned CELLS = 1 << AW;

    logic          clk = 1'b0;
    logic          nrst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_op;
    logic [DW-1:0] cmd_arg;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          cell_zero;
    logic [AW-1:0] ptr;

    tape_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .nrst(nrst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_arg(cmd_arg),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .cell_zero(cell_zero), .ptr(ptr)
    );

    always #5 clk = ~clk;

    // Tape RAM: combinational read, write on every clock.
    logic [DW-1:0] mem [CELLS];
    logic          mem_clear;
    assign ram_rdata = mem[ram_addr];
    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < CELLS; i++) mem[i] <= '0;
        end else begin
            mem[ram_addr] <= ram_wdata;
        end
    end

    logic [DW-1:0] exp_mem [CELLS];
    logic [AW-1:0] exp_ptr;
    logic [DW-1:0] exp_q [$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_mem(input string name);
        int bad = 0;
        n_checks++;
        for (int i = 0; i < CELLS; i++) begin
            if (mem[i] !== exp_mem[i]) begin
                bad++;
                $display("FAIL %s cell[%0d]: got %h expected %h", name, i, mem[i], exp_mem[i]);
            end
        end
        if (bad != 0) n_fail++;
    endtask

    // Issue one EXEC-class command; entered and left just after a falling edge.
    task automatic exec_cmd(input logic [2:0] op, input logic [DW-1:0] arg);
        logic [DW-1:0] exp_cell;
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL cmd_ready_before op%0d: got %b expected 1", op, cmd_ready);
        end
        case (op)
            3'd1: exp_mem[exp_ptr] = exp_mem[exp_ptr] + arg;
            3'd2: exp_mem[exp_ptr] = exp_mem[exp_ptr] - arg;
            3'd3: exp_ptr = exp_ptr + arg[AW-1:0];
            3'd4: exp_ptr = exp_ptr - arg[AW-1:0];
            default: ;
        endcase
        exp_q.push_back(exp_mem[exp_ptr]);
        cmd_valid = 1'b1; cmd_op = op; cmd_arg = arg;
        @(negedge clk);
        cmd_valid = 1'b0; cmd_op = 3'd0; cmd_arg = '0;
        n_checks++;
        if (cmd_ready !== 1'b0) begin
            n_fail++; $display("FAIL cmd_ready_exec op%0d: got %b expected 0", op, cmd_ready);
        end
        @(negedge clk);
        exp_cell = exp_q.pop_front();
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL cmd_ready_after op%0d: got %b expected 1", op, cmd_ready);
        end
        n_checks++;
        if (ptr !== exp_ptr) begin
            n_fail++; $display("FAIL ptr op%0d: got %0d expected %0d", op, ptr, exp_ptr);
        end
        n_checks++;
        if (ram_rdata !== exp_cell) begin
            n_fail++; $display("FAIL cell op%0d arg%0d: got %h expected %h", op, arg, ram_rdata, exp_cell);
        end
        n_checks++;
        if (cell_zero !== (exp_cell == '0)) begin
            n_fail++; $display("FAIL cell_zero op%0d: got %b expected %b", op, cell_zero, exp_cell == '0);
        end
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({cmd_ready, in_ready, out_valid, ptr, out_data} !== {1'b1, 1'b0, 1'b0, {AW{1'b0}}, {DW{1'b0}}}) begin
            n_fail++;
            $display("FAIL reset: got rdy=%b in_rdy=%b ov=%b ptr=%0d od=%h expected 1 0 0 0 00",
                     cmd_ready, in_ready, out_valid, ptr, out_data);
        end
        nrst = 1'b1;
        exp_ptr = '0;
        @(negedge clk);
    endtask

    task automatic test_inc();
        exec_cmd(3'd1, 8'd3);
        check_mem("inc");
    endtask

    task automatic test_wrap();
        exec_cmd(3'd3, 8'd1);
        exec_cmd(3'd2, 8'd1);
        exec_cmd(3'd1, 8'd1);
        exec_cmd(3'd4, 8'd1);
        check_mem("wrap");
    endtask

    task automatic test_ptr_wrap();
        exec_cmd(3'd4, 8'd1);
        exec_cmd(3'd3, 8'd65);
        check_mem("ptr_wrap");
    endtask

    task automatic test_in();
        int rdy_cycles = 0;
        exec_cmd(3'd3, 8'd4);
        cmd_valid = 1'b1; cmd_op = 3'd5; cmd_arg = 8'hEE;
        in_valid = 1'b0; in_data = 8'h13;
        exp_mem[exp_ptr] = 8'h41;
        exp_q.push_back(8'h41);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            if (in_ready === 1'b1) rdy_cycles++;
            if (i == 5) begin in_valid = 1'b1; in_data = 8'h41; end
        end
        @(negedge clk);
        in_valid = 1'b0; in_data = 8'h00;
        if (in_ready === 1'b1) rdy_cycles++;
        n_checks++;
        if (rdy_cycles != 6) begin
            n_fail++; $display("FAIL in_ready_cycles: got %0d expected 6", rdy_cycles);
        end
        n_checks++;
        if (ram_rdata !== exp_q.pop_front()) begin
            n_fail++; $display("FAIL in_cell: got %h expected 41", ram_rdata);
        end
        check_mem("in");
    endtask

    task automatic test_out();
        int  ov_cycles = 0;
        bit  unstable = 0;
        logic [DW-1:0] exp_byte;
        exec_cmd(3'd3, 8'd2);
        exec_cmd(3'd1, 8'h5A);
        cmd_valid = 1'b1; cmd_op = 3'd6; cmd_arg = 8'h77;
        out_ready = 1'b0;
        exp_q.push_back(exp_mem[exp_ptr]);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            if (out_valid === 1'b1) ov_cycles++;
            if (out_data !== 8'h5A) unstable = 1;
            if (i == 4) out_ready = 1'b1;
        end
        exp_byte = exp_q.pop_front();
        n_checks++;
        if (out_data !== exp_byte) begin
            n_fail++; $display("FAIL out_data: got %h expected %h", out_data, exp_byte);
        end
        @(negedge clk);
        out_ready = 1'b0;
        n_checks++;
        if (ov_cycles != 5 || unstable) begin
            n_fail++; $display("FAIL out_valid_window: got %0d cycles stable=%b expected 5 stable=1", ov_cycles, !unstable);
        end
        n_checks++;
        if (out_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL out_release: got ov=%b rdy=%b expected 0 1", out_valid, cmd_ready);
        end
        check_mem("out");
    endtask

    task automatic test_back_to_back();
        logic [2:0] ops [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd7};
        for (int i = 0; i < 30; i++) begin
            logic [DW-1:0] a;
            a = (i % 7 == 0) ? 8'd0 : DW'($urandom_range(0, 255));
            exec_cmd(ops[$urandom_range(0, 5)], a);
        end
        check_mem("back_to_back");
    endtask

    task automatic test_reset_mid();
        cmd_valid = 1'b1; cmd_op = 3'd6; cmd_arg = '0;
        out_ready = 1'b0;
        exp_q.push_back(exp_mem[exp_ptr]);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        nrst = 1'b0;
        void'(exp_q.pop_back());
        exp_ptr = '0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || cmd_ready !== 1'b1 || ptr !== exp_ptr) begin
            n_fail++; $display("FAIL reset_wait_out: got ov=%b rdy=%b ptr=%0d expected 0 1 0", out_valid, cmd_ready, ptr);
        end
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_wait_out_release: got ov=%b rdy=%b expected 0 1", out_valid, cmd_ready);
        end
        exec_cmd(3'd3, 8'd5);
        cmd_valid = 1'b1; cmd_op = 3'd1; cmd_arg = 8'd7;
        @(negedge clk);
        cmd_valid = 1'b0;
        nrst = 1'b0;
        exp_ptr = '0;
        #1;
        n_checks++;
        if (cmd_ready !== 1'b1 || ptr !== exp_ptr) begin
            n_fail++; $display("FAIL reset_exec: got rdy=%b ptr=%0d expected 1 0", cmd_ready, ptr);
        end
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        check_mem("reset_exec");
    endtask

    initial begin
        nrst = 1'b0; mem_clear = 1'b1;
        cmd_valid = 1'b0; cmd_op = '0; cmd_arg = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        for (int i = 0; i < CELLS; i++) exp_mem[i] = '0;
        exp_ptr = '0;
        repeat (2) @(negedge clk);
        mem_clear = 1'b0;
        test_reset();
        test_inc();
        test_wrap();
        test_ptr_wrap();
        test_in();
        test_out();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tape_ctrl.md
Name: tape_ctrl

Overview:
- Data-path controller that sits directly upstream of the tape RAM in the brainfuck CPU.
- Executes decoded tape commands from the instruction decoder: cell add/subtract, pointer move, input and output.
- Drives the RAM address and write data. The RAM writes on every clock, so this block always presents either the current cell value or the new one.
- Exposes a cell-is-zero flag for the loop logic and valid/ready byte streams for I/O.

Parameters:
DATA_WIDTH, 8, cell width in bits; also the width of cmd_arg and the I/O bytes.
ADDR_WIDTH, 6, tape address width; the tape holds 2^ADDR_WIDTH cells.

Ports:
clk  in  1  clock
nrst  in  1  reset, asynchronous, active-low
cmd_valid  in  1  command offered
cmd_ready  out  1  block can accept a command
cmd_op  in  3  0 NOP, 1 INC, 2 DEC, 3 RIGHT, 4 LEFT, 5 IN, 6 OUT, 7 reserved (treated as NOP)
cmd_arg  in  DATA_WIDTH  repeat amount for INC/DEC/RIGHT/LEFT; ignored otherwise
ram_addr  out  ADDR_WIDTH  tape address, always equal to ptr
ram_wdata  out  DATA_WIDTH  data the RAM writes this cycle
ram_rdata  in  DATA_WIDTH  combinational RAM read of ram_addr
in_valid  in  1  input byte available
in_ready  out  1  block consumes the input byte
in_data  in  DATA_WIDTH  input byte
out_valid  out  1  output byte valid
out_ready  in  1  sink accepts the output byte
out_data  out  DATA_WIDTH  output byte
cell_zero  out  1  ram_rdata == 0; meaningful only while cmd_ready = 1
ptr  out  ADDR_WIDTH  current data pointer

Behaviour:
- States: IDLE, EXEC, WAIT_IN, WAIT_OUT.
- Reset (async, nrst low): state IDLE, ptr 0, op/arg registers 0, out_valid 0, out_data 0.
  - Reset mid-operation abandons the command. A pending output byte is dropped; no input byte is consumed.
- ram_addr = ptr at all times.
- ram_wdata = ram_rdata (hold) unless stated otherwise below. No cell other than *ptr is ever altered.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid & cmd_ready, op and arg are registered. Next state: EXEC for ops 0-4 and 7, WAIT_IN for 5, WAIT_OUT for 6.
  - For OUT, out_data <= ram_rdata is captured on the handshake edge and out_valid <= 1.
- EXEC (exactly 1 cycle, cmd_ready = 0, then IDLE):
  - INC: ram_wdata = ram_rdata + arg, modulo 2^DATA_WIDTH.
  - DEC: ram_wdata = ram_rdata - arg, modulo 2^DATA_WIDTH.
  - RIGHT: ptr <= ptr + arg, modulo 2^ADDR_WIDTH. arg is truncated to its low ADDR_WIDTH bits.
  - LEFT: ptr <= ptr - arg, same wrap and truncation rules.
  - NOP / 7: no effect.
  - arg = 0 is legal and leaves all state unchanged.
- WAIT_IN:
  - in_ready = 1, cmd_ready = 0.
  - On in_valid, ram_wdata = in_data that cycle; next state IDLE.
  - Stalls indefinitely while in_valid = 0, holding the cell.
- WAIT_OUT:
  - cmd_ready = 0, out_valid = 1, out_data stable.
  - On out_ready, out_valid <= 0 and next state IDLE.
  - Stalls indefinitely while out_ready = 0.
- in_ready is 0 outside WAIT_IN. out_valid is 0 outside WAIT_OUT.
- Throughput:
  - INC/DEC/RIGHT/LEFT/NOP: one command per 2 cycles. A result is visible on ram_rdata and cell_zero in the IDLE cycle that follows EXEC.
  - IN/OUT: minimum 2 cycles each.
- cell_zero is combinational from ram_rdata. The loop decoder samples it only when cmd_ready = 1.
- The block never issues a combinational path from cmd_* to ram_wdata. Only registered op/arg and in_data feed ram_wdata.

Decomposition:
- Shared package tape_pkg:
  - op enum (NOP, INC, DEC, RIGHT, LEFT, IN, OUT) and its 3-bit width.
  - state enum.
  - DATA_WIDTH/ADDR_WIDTH defaults.
- No sub-module. The ALU is a single add/subtract expression inside this block. The RAM is instantiated alongside this block by the parent, not inside it.

Test Plan:
- Reset then INC arg 3 on cell 0 -> cell0 = 3; cmd_ready low for exactly 1 cycle; cell_zero = 0.
- DEC arg 1 on cell = 0 -> cell = 0xFF (wrap). A following INC arg 1 -> cell = 0x00 and cell_zero = 1.
- LEFT arg 1 at ptr 0 -> ptr = 63. RIGHT arg 65 at ptr 63 -> ptr = 0 (truncated to 1, then wrap). Cells 63 and 0 are unchanged.
- IN with in_valid held low 5 cycles, then in_data = 0x41 -> in_ready high for 6 cycles, cell = 0x41, no other cell written.
- Cell = 0x5A, OUT with out_ready low 4 cycles -> out_valid high and out_data = 0x5A stable for 5 cycles, drops after the handshake, cell unchanged.
- nrst asserted during WAIT_OUT and during EXEC of INC -> immediate IDLE, ptr 0, out_valid 0, cmd_ready 1 after release, pending increment not applied.
